nibble_bus_arbiter: RTL

- Shares the single external nibble memory bus (8-bit address/high field, 4-bit control field, 4-bit bidirectional data) between two requesters, e.g. CPU core and debug/DMA port.
- Owns the bus output/enable pins and sequences ownership with round-robin arbitration, lock support, a starvation limit and an optional turnaround cycle.
- Returns read data to the owning requester one cycle after each read transfer.

---
 rtl/nibble_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nibble_bus_arbiter.sv
// Two-requester arbiter for the shared nibble memory bus: round-robin ownership with lock,
// starvation limit, optional turnaround cycle and one-cycle-delayed read responses.
module nibble_bus_arbiter #(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic       req0_lock,
    input  logic [7:0] req0_addr,
    input  logic [3:0] req0_ctrl,
    input  logic [3:0] req0_wdata,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [3:0] rsp0_data,

    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic       req1_lock,
    input  logic [7:0] req1_addr,
    input  logic [3:0] req1_ctrl,
    input  logic [3:0] req1_wdata,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [3:0] rsp1_data,

    output logic [7:0] bus_addr,
    output logic [3:0] bus_ctrl,
    output logic [3:0] bus_wdata,
    output logic [7:0] bus_oe,
    input  logic [3:0] bus_rdata,
    output logic [1:0] bus_owner
);

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StTurn} state_t;

    state_t        state_q, state_d;
    logic          target_q, target_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rsp0_valid_q, rsp1_valid_q;
    logic [3:0]    rsp0_data_q, rsp1_data_q;

    // Current owner index and the view of both requesters from the owner's side.
    logic cur, own_valid, own_lock, oth_valid;

    always_comb begin
        cur       = (state_q == StOwn1);
        own_valid = cur ? req1_valid : req0_valid;
        own_lock  = cur ? req1_lock  : req0_lock;
        oth_valid = cur ? req0_valid : req1_valid;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        last_d   = last_q;
        hold_d   = hold_q;
        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0_valid) begin
                    state_d = StOwn0;
                end else if (req1_valid) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (oth_valid && (!own_lock || hold_q == HOLD_LAST)) begin
                    last_d   = cur;
                    target_d = !cur;
                    hold_d   = '0;
                    if (TURNAROUND != 0) begin
                        state_d = StTurn;
                    end else begin
                        state_d = cur ? StOwn0 : StOwn1;
                    end
                end else if (!own_valid && !own_lock) begin
                    state_d = StIdle;
                    last_d  = cur;
                    hold_d  = '0;
                end else if (oth_valid) begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    hold_d = '0;
                end
            end
            StTurn: begin
                hold_d  = '0;
                state_d = target_q ? StOwn1 : StOwn0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= 1'b0;
            last_q   <= 1'b1;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
        end
    end

    assign req0_ready = (state_q == StOwn0) && req0_valid;
    assign req1_ready = (state_q == StOwn1) && req1_valid;
    assign bus_owner  = {state_q == StOwn1, state_q == StOwn0};

    always_comb begin
        bus_addr  = 8'h00;
        bus_ctrl  = 4'h0;
        bus_wdata = 4'h0;
        bus_oe    = 8'hF0;
        if (req0_ready) begin
            bus_addr  = req0_addr;
            bus_ctrl  = req0_ctrl;
            bus_wdata = req0_write ? req0_wdata : 4'h0;
            bus_oe    = req0_write ? 8'hFF : 8'hF0;
        end else if (req1_ready) begin
            bus_addr  = req1_addr;
            bus_ctrl  = req1_ctrl;
            bus_wdata = req1_write ? req1_wdata : 4'h0;
            bus_oe    = req1_write ? 8'hFF : 8'hF0;
        end
    end

    // Read data is captured on the transfer edge and presented for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 4'h0;
            rsp1_data_q  <= 4'h0;
        end else begin
            rsp0_valid_q <= req0_ready && !req0_write;
            rsp1_valid_q <= req1_ready && !req1_write;
            if (req0_ready && !req0_write) begin
                rsp0_data_q <= bus_rdata;
            end
            if (req1_ready && !req1_write) begin
                rsp1_data_q <= bus_rdata;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

endmodule
